// File: rtl/uart_msg_seq_if.sv
// Handshake to uart_tx plus the message-buffer write port, bundled for uart_msg_seq.
// The master side is the sequencer. It drives tx_start/tx_data and receives tx_rdy and the buffer writes.
interface uart_msg_seq_if #(
   parameter int ADDR_W = 4
) ();
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_rdy;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (
      output tx_start, tx_data,
      input  tx_rdy, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  tx_start, tx_data,
      output tx_rdy, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/uart_msg_seq.sv
// Message sequencer: streams the first min(msg_len, DEPTH) bytes of a writable buffer
// into uart_tx via its start/rdy handshake, in one-shot or repeat mode, with an idle gap.
module uart_msg_seq #(
   parameter int ADDR_W = 4,
   parameter int GAP_W  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              one_shot,
   input  logic [ADDR_W:0]   msg_len,
   input  logic [GAP_W-1:0]  gap,
   uart_msg_seq_if.master    bus,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] char_idx,
   output logic [CNT_W-1:0]  msg_cnt
);
   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      ADVANCE,
      GAP,
      HOLD
   } state_t;

   // Power-on pattern "ABCD\r\nabcd\r\n", padded with '.'; shorter buffers keep the prefix.
   function automatic logic [7:0] default_byte(input int idx);
      logic [7:0] b;
      case (idx)
         0:       b = 8'h41;
         1:       b = 8'h42;
         2:       b = 8'h43;
         3:       b = 8'h44;
         4:       b = 8'h0D;
         5:       b = 8'h0A;
         6:       b = 8'h61;
         7:       b = 8'h62;
         8:       b = 8'h63;
         9:       b = 8'h64;
         10:      b = 8'h0D;
         11:      b = 8'h0A;
         default: b = 8'h2E;
      endcase
      return b;
   endfunction

   logic [7:0] mem_reg [DEPTH];

   state_t            state_reg,    state_next;
   logic [ADDR_W-1:0] char_idx_reg, char_idx_next;
   logic [ADDR_W:0]   len_reg,      len_next;
   logic [GAP_W-1:0]  gap_cnt_reg,  gap_cnt_next;
   logic [CNT_W-1:0]  msg_cnt_reg,  msg_cnt_next;
   logic [7:0]        tx_data_reg,  tx_data_next;

   logic [ADDR_W:0]   len_clamped;
   logic [ADDR_W-1:0] char_idx_inc;
   logic              last_char;
   logic              tx_start_c;
   logic              done_c;

   // Writes land in any state; bytes already latched into tx_data are unaffected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= default_byte(i);
         end
      end else if (bus.wr_en) begin
         mem_reg[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign len_clamped  = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
   assign char_idx_inc = char_idx_reg + ADDR_W'(1);
   assign last_char    = ({1'b0, char_idx_reg} == (len_reg - ONE_L));

   always_comb begin
      state_next    = state_reg;
      char_idx_next = char_idx_reg;
      len_next      = len_reg;
      gap_cnt_next  = gap_cnt_reg;
      msg_cnt_next  = msg_cnt_reg;
      tx_data_next  = tx_data_reg;
      tx_start_c    = 1'b0;
      done_c        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (en && (msg_len != '0)) begin
               len_next      = len_clamped;
               char_idx_next = '0;
               tx_data_next  = mem_reg[0];
               state_next    = ISSUE;
            end
         end

         ISSUE: begin
            // A transmitter already busy on entry still counts the byte as issued.
            tx_start_c = bus.tx_rdy;
            if (!bus.tx_rdy) begin
               state_next = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            if (bus.tx_rdy) begin
               state_next = ADVANCE;
            end
         end

         ADVANCE: begin
            if (last_char) begin
               done_c       = 1'b1;
               msg_cnt_next = msg_cnt_reg + CNT_W'(1);
               if (one_shot) begin
                  state_next = HOLD;
               end else if (!en) begin
                  state_next = IDLE;
               end else begin
                  char_idx_next = '0;
                  len_next      = len_clamped;
                  if (len_clamped == '0) begin
                     state_next = IDLE;
                  end else if (gap != '0) begin
                     gap_cnt_next = gap;
                     state_next   = GAP;
                  end else begin
                     tx_data_next = mem_reg[0];
                     state_next   = ISSUE;
                  end
               end
            end else if (!en) begin
               state_next = IDLE;
            end else begin
               char_idx_next = char_idx_inc;
               if (gap != '0) begin
                  gap_cnt_next = gap;
                  state_next   = GAP;
               end else begin
                  tx_data_next = mem_reg[char_idx_inc];
                  state_next   = ISSUE;
               end
            end
         end

         GAP: begin
            if (!en) begin
               state_next = IDLE;
            end else if (gap_cnt_reg == GAP_W'(1)) begin
               tx_data_next = mem_reg[char_idx_reg];
               state_next   = ISSUE;
            end else begin
               gap_cnt_next = gap_cnt_reg - GAP_W'(1);
            end
         end

         HOLD: begin
            // One-shot rearms only after en has been released.
            if (!en) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         char_idx_reg <= '0;
         len_reg      <= '0;
         gap_cnt_reg  <= '0;
         msg_cnt_reg  <= '0;
         tx_data_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         char_idx_reg <= char_idx_next;
         len_reg      <= len_next;
         gap_cnt_reg  <= gap_cnt_next;
         msg_cnt_reg  <= msg_cnt_next;
         tx_data_reg  <= tx_data_next;
      end
   end

   assign bus.tx_start = tx_start_c;
   assign bus.tx_data  = tx_data_reg;
   assign done         = done_c;
   assign busy         = (state_reg != IDLE) && (state_reg != HOLD);
   assign char_idx     = char_idx_reg;
   assign msg_cnt      = msg_cnt_reg;

endmodule

// File: tb/tb_uart_msg_seq.sv
// Bench for uart_msg_seq: a behavioural uart_tx and a byte-array reference model
// predict every byte sent, the pass counts and the character spacing.
`timescale 1ns/1ps
module tb_uart_msg_seq;
   localparam int ADDR_W = 4;
   localparam int GAP_W  = 16;
   localparam int CNT_W  = 16;
   localparam int DEPTH  = 16;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic              en       = 1'b0;
   logic              one_shot = 1'b0;
   logic [ADDR_W:0]   msg_len  = '0;
   logic [GAP_W-1:0]  gap      = '0;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] char_idx;
   logic [CNT_W-1:0]  msg_cnt;

   uart_msg_seq_if #(.ADDR_W(ADDR_W)) bus ();

   uart_msg_seq #(.ADDR_W(ADDR_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .one_shot (one_shot),
      .msg_len  (msg_len),
      .gap      (gap),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .char_idx (char_idx),
      .msg_cnt  (msg_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: buffer contents as the host believes them to be.
   logic [7:0] ref_mem [DEPTH];
   logic [7:0] pat [12] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A,
                            8'h61, 8'h62, 8'h63, 8'h64, 8'h0D, 8'h0A};
   int exp_msg_cnt = 0;

   // Behavioural uart_tx: accepts a start while ready, then stays busy tx_busy cycles.
   logic       model_rdy = 1'b1;
   int         busy_left = 0;
   int         tx_busy   = 10;
   int         cyc       = 0;
   int         done_seen = 0;
   logic [7:0] cap_q   [$];
   int         start_q [$];
   int         rise_q  [$];

   assign bus.tx_rdy = model_rdy;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         model_rdy = 1'b1;
         busy_left = 0;
      end else begin
         if (done) done_seen++;
         if (!model_rdy) begin
            busy_left--;
            if (busy_left <= 0) begin
               model_rdy = 1'b1;
               rise_q.push_back(cyc);
            end
         end else if (bus.tx_start) begin
            cap_q.push_back(bus.tx_data);
            start_q.push_back(cyc);
            model_rdy = 1'b0;
            busy_left = tx_busy;
         end
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic reset_ref();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i < 12) ? pat[i] : 8'h2E;
   endtask

   task automatic clear_log();
      cap_q.delete();
      start_q.delete();
      rise_q.delete();
      done_seen = 0;
   endtask

   task automatic buf_write(input int a, input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a[ADDR_W-1:0];
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
      ref_mem[a]  = d;
   endtask

   function automatic int cap_at(input int i);
      if (i < cap_q.size()) return int'(cap_q[i]);
      return -1;
   endfunction

   // One-shot pass: expects the first exp_n model bytes, one done, then HOLD with en still high.
   task automatic run_oneshot(input string tag, input int len, input int g, input int bsy,
                              input int exp_n, input int exp_space);
      int t;
      clear_log();
      tx_busy  = bsy;
      msg_len  = len[ADDR_W:0];
      gap      = g[GAP_W-1:0];
      one_shot = 1'b1;
      en       = 1'b1;
      t = 0;
      if (exp_n > 0) begin
         while (done_seen == 0 && t < 2000) begin
            tick();
            t++;
         end
         check({tag, "_done_seen"}, (done_seen > 0) ? 1 : 0, 1);
         exp_msg_cnt++;
      end
      repeat (30) tick();
      check({tag, "_count"}, cap_q.size(), exp_n);
      for (int i = 0; i < exp_n; i++) check($sformatf("%s_byte%0d", tag, i), cap_at(i), ref_mem[i]);
      check({tag, "_done_pulses"}, done_seen, (exp_n > 0) ? 1 : 0);
      check({tag, "_busy_hold"}, busy, 0);
      check({tag, "_msg_cnt"}, msg_cnt, exp_msg_cnt % 65536);
      if (exp_space >= 0 && start_q.size() >= 2 && rise_q.size() >= 1)
         check({tag, "_spacing"}, start_q[1] - rise_q[0], exp_space);
      $display("run %s len=%0d gap=%0d busy=%0d sent=%0d msg_cnt=%0d", tag, len, g, bsy, cap_q.size(), msg_cnt);
      en = 1'b0;
      repeat (3) tick();
   endtask

   typedef struct {
      int len;
      int gap;
      int bsy;
      int exp_n;
      int exp_space;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, len, g, b, exp_n;

      vecs[0] = '{4,  0, 10,  4,  2};
      vecs[1] = '{4,  0, 10,  4,  2};
      vecs[2] = '{2,  5, 10,  2,  7};
      vecs[3] = '{2,  0,  3,  2,  2};
      vecs[4] = '{20, 0,  2, 16,  2};
      vecs[5] = '{0,  0, 10,  0, -1};
      vecs[6] = '{1,  3,  4,  1, -1};

      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      reset_ref();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("rst_busy", busy, 0);
      check("rst_tx_start", bus.tx_start, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_done", done, 0);
      check("rst_char_idx", char_idx, 0);
      check("rst_msg_cnt", msg_cnt, 0);

      // Continuous repeat of the full default message, three passes.
      clear_log();
      tx_busy = 10; msg_len = 12; gap = 0; one_shot = 1'b0; en = 1'b1;
      for (int p = 0; p < 3; p++) begin
         t = 0;
         while (!done && t < 1000) begin
            tick();
            t++;
         end
         check($sformatf("cont_done%0d", p), done, 1);
         check($sformatf("cont_cnt_before%0d", p), msg_cnt, p);
         check($sformatf("cont_bytes_at_done%0d", p), cap_q.size(), 12 * (p + 1));
         if (p == 2) en = 1'b0;
         tick();
      end
      repeat (5) tick();
      exp_msg_cnt = 3;
      check("cont_msg_cnt", msg_cnt, 3);
      check("cont_busy_off", busy, 0);
      check("cont_total", cap_q.size(), 36);
      for (int i = 0; i < 36; i++) check($sformatf("cont_byte%0d", i), cap_at(i), ref_mem[i % 12]);
      $display("run continuous len=12 sent=%0d msg_cnt=%0d", cap_q.size(), msg_cnt);

      // Table of one-shot runs: rearm, gap spacing, clamping, zero length.
      for (int v = 0; v < 7; v++)
         run_oneshot($sformatf("vec%0d", v), vecs[v].len, vecs[v].gap, vecs[v].bsy,
                     vecs[v].exp_n, vecs[v].exp_space);

      // Write to the in-flight address: current byte unchanged, next pass sees it.
      clear_log();
      tx_busy = 10; msg_len = 4; gap = 0; one_shot = 1'b0; en = 1'b1;
      t = 0;
      while (cap_q.size() < 2 && t < 500) begin tick(); t++; end
      check("wr_reach_char1", cap_q.size(), 2);
      buf_write(1, 8'h5A);
      check("wr_inflight_tx_data", bus.tx_data, 8'h42);
      t = 0;
      while (cap_q.size() < 6 && t < 500) begin tick(); t++; end
      en = 1'b0;
      t = 0;
      while (busy && t < 500) begin tick(); t++; end
      exp_msg_cnt++;
      check("wr_old_byte", cap_at(1), 8'h42);
      check("wr_new_byte", cap_at(5), 8'h5A);
      check("wr_total", cap_q.size(), 6);
      check("wr_msg_cnt", msg_cnt, exp_msg_cnt);
      $display("run write_in_flight sent=%0d msg_cnt=%0d", cap_q.size(), msg_cnt);

      // en dropped while character 3 is in flight.
      clear_log();
      msg_len = 12; en = 1'b1;
      t = 0;
      while (cap_q.size() < 4 && t < 500) begin tick(); t++; end
      en = 1'b0;
      repeat (40) tick();
      check("endrop_count", cap_q.size(), 4);
      check("endrop_done", done_seen, 0);
      check("endrop_busy", busy, 0);
      check("endrop_msg_cnt", msg_cnt, exp_msg_cnt);
      for (int i = 0; i < 4; i++) check($sformatf("endrop_byte%0d", i), cap_at(i), ref_mem[i]);
      $display("run en_drop sent=%0d", cap_q.size());

      // Randomised one-shot passes against the reference model.
      for (int r = 0; r < 20; r++) begin
         for (int w = 0; w < 3; w++) buf_write(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
         len   = int'($urandom_range(0, 20));
         g     = int'($urandom_range(0, 4));
         b     = int'($urandom_range(1, 6));
         exp_n = (len > DEPTH) ? DEPTH : len;
         run_oneshot($sformatf("rnd%0d", r), len, g, b, exp_n, 2 + g);
      end

      // Reset during WAIT_DONE in the second pass.
      clear_log();
      tx_busy = 10; msg_len = 12; gap = 0; one_shot = 1'b0; en = 1'b1;
      t = 0;
      while (cap_q.size() < 14 && t < 1000) begin tick(); t++; end
      tick();
      check("mid_wait_state_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_tx_start", bus.tx_start, 0);
      check("mid_rst_tx_data", bus.tx_data, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_char_idx", char_idx, 0);
      check("mid_rst_msg_cnt", msg_cnt, 0);
      $display("run reset_mid_char msg_cnt=%0d busy=%0d", msg_cnt, busy);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      reset_ref();
      exp_msg_cnt = 0;
      run_oneshot("post_reset", 12, 0, 10, 12, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_msg_seq.md
Name: uart_msg_seq

Overview:
- Parametrised message sequencer that feeds a byte-wide UART transmitter through its start/rdy handshake.
- Holds a writable message buffer and sends its first msg_len bytes in order.
- Modes: continuous repeat or one-shot, with a programmable idle gap between characters.
- Sits between host/config logic and uart_tx; it is the next generation of the fixed-string bring-up pattern generator.

Parameters:
- ADDR_W, 4, buffer address width; DEPTH = 2**ADDR_W entries of 8 bits.
- GAP_W, 16, width of the inter-character gap counter.
- CNT_W, 16, width of the completed-message counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable
- one_shot  in  1  1 = send the message once per en assertion; 0 = repeat
- msg_len  in  ADDR_W+1  characters per message; 0 = send nothing; values above DEPTH are clamped to DEPTH
- gap  in  GAP_W  idle cycles inserted after each character
- wr_en  in  1  buffer write strobe
- wr_addr  in  ADDR_W  buffer write address
- wr_data  in  8  buffer write data
- tx_rdy  in  1  transmitter ready, from uart_tx rdy
- tx_start  out  1  start request to uart_tx
- tx_data  out  8  byte to uart_tx din
- busy  out  1  high in any state except IDLE/HOLD
- done  out  1  one-cycle pulse when the last character of a pass completes
- char_idx  out  ADDR_W  index of the current character
- msg_cnt  out  CNT_W  completed passes; wraps modulo 2**CNT_W

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: state=IDLE, tx_data=0, done=0, char_idx=0, msg_cnt=0, busy=0, tx_start=0.
  - Buffer preloads "ABCD\r\nabcd\r\n" (0x41 0x42 0x43 0x44 0x0D 0x0A 0x61 0x62 0x63 0x64 0x0D 0x0A) into entries 0..11. All other entries load 0x2E.
  - If DEPTH<12, the pattern is truncated.
- Reset mid-character aborts immediately; no completion is owed to uart_tx.
- Buffer writes are accepted in every state, one per cycle.
  - tx_data is latched at ISSUE entry.
  - A write to the address being sent does not change the byte in flight. It takes effect on the next pass.
- Latched length: L = min(msg_len, DEPTH), latched at each pass start. Changing msg_len mid-pass has no effect until the next pass.
- FSM:
  - IDLE: if en=1 and msg_len!=0, latch L, char_idx<=0, tx_data<=buf[0], go to ISSUE. Otherwise stay.
  - ISSUE: tx_start = tx_rdy (combinational; 0 in every other state). When tx_rdy=0 is sampled, go to WAIT_DONE. tx_data is held.
  - WAIT_DONE: when tx_rdy=1, go to ADVANCE.
  - ADVANCE (one cycle), three cases in priority order:
    - Last character (char_idx==L-1): done=1 for this cycle, msg_cnt+1. Then:
      - one_shot=1 -> HOLD
      - en=0 -> IDLE
      - otherwise char_idx<=0, relatch L, go to GAP if gap!=0, else load buf[0] and go to ISSUE.
    - Not last, en=0: go to IDLE. The current character has finished; there is no truncation and no done.
    - Otherwise: char_idx+1, then GAP if gap!=0, else load the next byte and go to ISSUE.
  - GAP: counts exactly gap cycles. Then loads buf[char_idx] into tx_data and goes to ISSUE. If en drops during GAP, go to IDLE immediately.
  - HOLD: wait for en=0, then go to IDLE. This makes one-shot rearm only on a fresh en assertion.
- Character-to-character spacing: ADVANCE->ISSUE takes 1 cycle with gap=0, or 1+gap cycles otherwise (plus transmitter frame time).
- If tx_rdy is already 0 on entering ISSUE, tx_start stays 0 and the FSM moves to WAIT_DONE on the next edge. The byte is counted as sent. uart_tx is expected to hold rdy=1 whenever idle.
- msg_len=0 while running: takes effect at the next pass boundary. A latched L of 0 from the next pass-start takes the IDLE path (no start).

Test Plan:
- Reset, en=1, one_shot=0, msg_len=12, gap=0, model uart_tx with 10-cycle busy -> bytes 41 42 43 44 0D 0A 61 62 63 64 0D 0A repeat; done pulses every 12 chars; msg_cnt counts 1,2,3.
- one_shot=1, msg_len=4, en held high -> exactly 41 42 43 44 sent, one done, FSM in HOLD, busy=0. Drop en, raise it again -> second identical burst, msg_cnt=2.
- gap=5, msg_len=2 -> measured cycles from tx_rdy rise (end of char 0) to tx_start of char 1 = 1+5+1. Zero-gap case gives 2.
- Write wr_addr=1, wr_data=0x5A while char 1 is in flight -> the in-flight byte stays 0x42; the next pass sends 0x5A at index 1.
- Drop en mid-character 3 -> character completes, no tx_start follows, done=0, FSM in IDLE. msg_len=20 with ADDR_W=4 -> 16 chars per pass. msg_len=0 with en=1 -> tx_start never asserts.
- Assert rst_n=0 during WAIT_DONE -> all outputs return to reset values within the same cycle; the buffer is restored to the default pattern.
